// File: rtl/game_pkg.sv
// Shared state encoding and check_hit result codes for the game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RELEASE,
    REQ,
    ARM,
    OVER
  } state_t;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_LIFE  = 2'b01;
  localparam logic [1:0] RES_POINT = 2'b11;

endpackage

// File: rtl/down_timer.sv
// Loadable down counter that stops at zero; zero flag is derived from the count register.
module down_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/round_controller.sv
// Game sequencer: requests targets, arms check_hit, scores hits, charges lives on misses/timeouts.
module round_controller
  import game_pkg::*;
#(
  parameter int SCORE_W      = 8,
  parameter int LIVES_W      = 2,
  parameter int START_LIVES  = 3,
  parameter int TIMEOUT_CYC  = 50_000_000,
  parameter int TIMEOUT_STEP = 1_000_000,
  parameter int TIMEOUT_MIN  = 10_000_000,
  parameter int SETTLE_CYC   = 1_000_000,
  parameter int TMR_W        = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_btn_n,
  input  logic [3:0]         buttons_n,
  input  logic [1:0]         give_point_life,
  output logic               start_checks,
  output logic               new_round,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               game_over
);

  localparam logic [TMR_W-1:0]   WIN_INIT    = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]   WIN_STEP    = TMR_W'(TIMEOUT_STEP);
  localparam logic [TMR_W-1:0]   WIN_MIN     = TMR_W'(TIMEOUT_MIN);
  localparam logic [TMR_W-1:0]   SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(START_LIVES);

  state_t             state_reg;
  logic [1:0]         gpl_q;
  logic               first_arm_reg;
  logic [TMR_W-1:0]   cur_window_reg;

  logic               released;
  logic               settle_load;
  logic               settle_en;
  logic               settle_zero;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_zero;
  logic [TMR_W-1:0]   tmr_load_val;
  logic [TMR_W-1:0]   window_next;
  logic [LIVES_W-1:0] lives_next;
  logic [SCORE_W-1:0] score_next;

  assign released     = (buttons_n == 4'hF) && start_btn_n;
  // Settle counter sits preloaded outside RELEASE and reloads on any press.
  assign settle_load  = (state_reg != RELEASE) || !released;
  assign settle_en    = (state_reg == RELEASE);
  assign tmr_load     = (state_reg == REQ);
  assign tmr_en       = (state_reg == ARM);
  assign tmr_load_val = cur_window_reg - TMR_W'(1);

  assign lives_next = (lives != '0) ? lives - LIVES_W'(1) : '0;
  assign score_next = (score != '1) ? score + SCORE_W'(1) : score;

  // Shrink the window by one step, clamped to the floor without ever underflowing.
  always_comb begin
    window_next = WIN_MIN;
    if ((cur_window_reg > WIN_MIN) && ((cur_window_reg - WIN_MIN) > WIN_STEP)) begin
      window_next = cur_window_reg - WIN_STEP;
    end
  end

  down_timer #(.W(TMR_W)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (settle_load),
    .load_val (SETTLE_LOAD),
    .en       (settle_en),
    .zero     (settle_zero)
  );

  down_timer #(.W(TMR_W)) u_react (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      gpl_q          <= RES_NONE;
      first_arm_reg  <= 1'b0;
      cur_window_reg <= WIN_INIT;
      score          <= '0;
      lives          <= LIVES_INIT;
      start_checks   <= 1'b0;
      new_round      <= 1'b0;
      hit_pulse      <= 1'b0;
      miss_pulse     <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      gpl_q      <= give_point_life;
      new_round  <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state_reg)
        IDLE, OVER: begin
          if (!start_btn_n) begin
            state_reg      <= RELEASE;
            score          <= '0;
            lives          <= LIVES_INIT;
            cur_window_reg <= WIN_INIT;
            game_over      <= 1'b0;
          end
        end
        RELEASE: begin
          if (released && settle_zero) begin
            state_reg <= REQ;
            new_round <= 1'b1;
          end
        end
        REQ: begin
          state_reg     <= ARM;
          start_checks  <= 1'b1;
          first_arm_reg <= 1'b1;
        end
        ARM: begin
          first_arm_reg <= 1'b0;
          // check_hit still shows its disarmed value on the first armed cycle.
          if (!first_arm_reg) begin
            if (gpl_q == RES_POINT) begin
              score          <= score_next;
              hit_pulse      <= 1'b1;
              cur_window_reg <= window_next;
              start_checks   <= 1'b0;
              state_reg      <= RELEASE;
            end else if ((gpl_q == RES_LIFE) || tmr_zero) begin
              lives        <= lives_next;
              miss_pulse   <= 1'b1;
              start_checks <= 1'b0;
              if (lives_next == '0) begin
                state_reg <= OVER;
                game_over <= 1'b1;
              end else begin
                state_reg <= RELEASE;
              end
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          start_checks <= 1'b0;
          game_over    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller using shortened windows (20/5/8, settle 3, 3 lives).
module tb_round_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_btn_n;
  logic [3:0] buttons_n;
  logic [1:0] give_point_life;
  logic       start_checks;
  logic       new_round;
  logic [7:0] score;
  logic [1:0] lives;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  round_controller #(
    .SCORE_W      (8),
    .LIVES_W      (2),
    .START_LIVES  (3),
    .TIMEOUT_CYC  (20),
    .TIMEOUT_STEP (5),
    .TIMEOUT_MIN  (8),
    .SETTLE_CYC   (3),
    .TMR_W        (26)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_btn_n     (start_btn_n),
    .buttons_n       (buttons_n),
    .give_point_life (give_point_life),
    .start_checks    (start_checks),
    .new_round       (new_round),
    .score           (score),
    .lives           (lives),
    .hit_pulse       (hit_pulse),
    .miss_pulse      (miss_pulse),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Ticks until new_round is seen; n = ticks taken, -1 if it never came.
  task automatic wait_nr(output int n);
    n = -1;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (new_round) begin
        n = t;
        break;
      end
    end
  endtask

  // Starts at the REQ negedge. A code driven at tick k-1 is seen by the FSM in ARM cycle k.
  // k=0 means no response. Returns ticks until a hit/miss pulse appears.
  task automatic play_round(input int k, input logic [1:0] code, input logic stale,
                            output int ticks, output logic hit, output logic miss,
                            output logic sc);
    give_point_life = stale ? 2'b11 : 2'b00;
    ticks = -1;
    hit   = 1'b0;
    miss  = 1'b0;
    sc    = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (t == 1) begin
        sc = start_checks;
        give_point_life = 2'b00;
      end
      if (hit_pulse || miss_pulse) begin
        ticks = t;
        hit   = hit_pulse;
        miss  = miss_pulse;
        break;
      end
      if (k > 0 && t == k - 1) give_point_life = code;
      else if (t == k) give_point_life = 2'b00;
    end
    give_point_life = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_btn_n = 1'b1;
    buttons_n = 4'hF;
    give_point_life = 2'b00;
    repeat (3) tick();
    n_checks++;
    if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
    n_checks++;
    if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d expected 3", lives); end
    n_checks++;
    if ({start_checks, new_round, hit_pulse, miss_pulse, game_over} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {start_checks, new_round, hit_pulse, miss_pulse, game_over});
    end
    rst_n = 1'b1;
    repeat (4) tick();
    n_checks++;
    if ({start_checks, new_round} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_hold: got %b expected 00", {start_checks, new_round});
    end
    $display("test_reset done");
  endtask

  task automatic test_start();
    int n;
    start_btn_n = 1'b0;
    tick();
    start_btn_n = 1'b1;
    n_checks++;
    if (new_round !== 1'b0 || start_checks !== 1'b0) begin
      n_fail++;
      $display("FAIL start_release: got nr=%b sc=%b expected nr=0 sc=0", new_round, start_checks);
    end
    wait_nr(n);
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL start_settle: got %0d ticks expected 3", n); end
    $display("test_start new_round after %0d ticks", n);
  endtask

  // Windows 20 -> 15 -> 10 -> 8 -> 8, last-cycle hits, stale result, timeouts to game over.
  task automatic test_hits_and_timeouts();
    int         k_t[8]   = '{2, 0, 15, 0, 10, 8, 5, 0};
    logic       st_t[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int         tk_t[8]  = '{3, 16, 16, 11, 11, 9, 6, 9};
    logic       hit_t[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int         sc_t[8]  = '{1, 1, 2, 2, 3, 4, 5, 5};
    int         lv_t[8]  = '{3, 2, 2, 1, 1, 1, 1, 0};
    int         ticks, n, nr_cnt;
    logic       hit, miss, sc;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        wait_nr(n);
        n_checks++;
        if (n !== 2) begin n_fail++; $display("FAIL round%0d_settle: got %0d expected 2", i, n); end
      end
      play_round(k_t[i], 2'b11, st_t[i], ticks, hit, miss, sc);
      $display("round %0d: ticks=%0d hit=%b miss=%b score=%0d lives=%0d over=%b",
               i, ticks, hit, miss, score, lives, game_over);
      n_checks++;
      if (sc !== 1'b1) begin n_fail++; $display("FAIL round%0d_arm: start_checks=%b expected 1", i, sc); end
      n_checks++;
      if (ticks !== tk_t[i]) begin n_fail++; $display("FAIL round%0d_ticks: got %0d expected %0d", i, ticks, tk_t[i]); end
      n_checks++;
      if (hit !== hit_t[i] || miss !== !hit_t[i]) begin
        n_fail++;
        $display("FAIL round%0d_pulse: got hit=%b miss=%b expected hit=%b", i, hit, miss, hit_t[i]);
      end
      n_checks++;
      if (score !== 8'(sc_t[i]) || lives !== 2'(lv_t[i])) begin
        n_fail++;
        $display("FAIL round%0d_count: got score=%0d lives=%0d expected %0d/%0d", i, score, lives, sc_t[i], lv_t[i]);
      end
      n_checks++;
      if (game_over !== (i == 7) || start_checks !== 1'b0) begin
        n_fail++;
        $display("FAIL round%0d_state: got over=%b sc=%b expected over=%b sc=0", i, game_over, start_checks, (i == 7));
      end
      tick();
      n_checks++;
      if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL round%0d_onepulse: got hit=%b miss=%b expected 0/0", i, hit_pulse, miss_pulse);
      end
    end
    nr_cnt = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (new_round) nr_cnt++;
    end
    n_checks++;
    if (nr_cnt !== 0 || score !== 8'd5 || game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL over_hold: got nr=%0d score=%0d over=%b expected 0/5/1", nr_cnt, score, game_over);
    end
  endtask

  // Restart from OVER with start held, wrong button, button held through RELEASE.
  task automatic test_wrong_and_settle();
    int   ticks, n, nr_cnt;
    logic hit, miss, sc;
    start_btn_n = 1'b0;
    repeat (3) tick();
    start_btn_n = 1'b1;
    n_checks++;
    if (score !== 8'd0 || lives !== 2'd3 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: got score=%0d lives=%0d over=%b expected 0/3/0", score, lives, game_over);
    end
    wait_nr(n);
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL restart_settle: got %0d expected 3", n); end
    play_round(3, 2'b01, 1'b0, ticks, hit, miss, sc);
    $display("wrong button: ticks=%0d hit=%b miss=%b lives=%0d", ticks, hit, miss, lives);
    n_checks++;
    if (ticks !== 4 || hit !== 1'b0 || miss !== 1'b1 || lives !== 2'd2) begin
      n_fail++;
      $display("FAIL wrong_button: got ticks=%0d hit=%b miss=%b lives=%0d expected 4/0/1/2", ticks, hit, miss, lives);
    end
    buttons_n = 4'hB;
    nr_cnt = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (new_round) nr_cnt++;
    end
    n_checks++;
    if (nr_cnt !== 0) begin n_fail++; $display("FAIL held_button: got %0d new_round expected 0", nr_cnt); end
    buttons_n = 4'hF;
    wait_nr(n);
    $display("settle after release: %0d ticks", n);
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL release_settle: got %0d expected 3", n); end
  endtask

  task automatic test_reset_mid_arm();
    int   ticks, n;
    logic hit, miss, sc;
    play_round(2, 2'b11, 1'b0, ticks, hit, miss, sc);
    n_checks++;
    if (score !== 8'd1 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_hit: got score=%0d hit=%b expected 1/1", score, hit);
    end
    wait_nr(n);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    $display("mid-ARM reset: score=%0d lives=%0d sc=%b over=%b", score, lives, start_checks, game_over);
    n_checks++;
    if (score !== 8'd0 || lives !== 2'd3 || start_checks !== 1'b0 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got score=%0d lives=%0d sc=%b over=%b expected 0/3/0/0",
               score, lives, start_checks, game_over);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (new_round !== 1'b0 || start_checks !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_to_idle: got nr=%b sc=%b expected 0/0", new_round, start_checks);
    end
  endtask

  task automatic test_saturation();
    int         ticks, n;
    logic       hit, miss, sc;
    logic [7:0] score_255;
    start_btn_n = 1'b0;
    tick();
    start_btn_n = 1'b1;
    wait_nr(n);
    score_255 = 8'd0;
    for (int i = 0; i < 256; i++) begin
      play_round(2, 2'b11, 1'b0, ticks, hit, miss, sc);
      if (i == 254) score_255 = score;
      if (i < 255) begin
        tick();
        wait_nr(n);
      end
    end
    $display("saturation: after 255 hits score=%0d, after 256 score=%0d hit=%b", score_255, score, hit);
    n_checks++;
    if (score_255 !== 8'd255) begin n_fail++; $display("FAIL score_255: got %0d expected 255", score_255); end
    n_checks++;
    if (score !== 8'd255 || hit !== 1'b1 || lives !== 2'd3) begin
      n_fail++;
      $display("FAIL score_saturate: got score=%0d hit=%b lives=%0d expected 255/1/3", score, hit, lives);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hits_and_timeouts();
    test_wrong_and_settle();
    test_reset_mid_arm();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
